// File: rtl/anton_neopixel_pixel_buffer_if.sv
// APB3 slave bus bundle for the NeoPixel pixel buffer.
// The master drives address/control/data; the slave returns read data, ready and error.
interface anton_neopixel_pixel_buffer_if;
  logic [7:0] APB_PADDR;
  logic       APB_PSELx;
  logic       APB_PENABLE;
  logic       APB_PWRITE;
  logic [7:0] APB_PWDATA;
  logic [7:0] APB_PRDATA;
  logic       APB_PREADY;
  logic       APB_PSLVERR;

  modport master (
    output APB_PADDR, APB_PSELx, APB_PENABLE, APB_PWRITE, APB_PWDATA,
    input  APB_PRDATA, APB_PREADY, APB_PSLVERR
  );

  modport slave (
    input  APB_PADDR, APB_PSELx, APB_PENABLE, APB_PWRITE, APB_PWDATA,
    output APB_PRDATA, APB_PREADY, APB_PSLVERR
  );
endinterface

// File: rtl/anton_neopixel_pixel_buffer.sv
// APB-writable RGB332 pixel store feeding the NeoPixel serialiser, with frame-aligned bank swap.
// Define ANTON_NEOPIXEL_DOUBLE_BUFFER_EN for two banks and the swap FSM; otherwise a single bank.
module anton_neopixel_pixel_buffer #(
  parameter int PIXELS_MAX  = 5,
  parameter int PIXELS_BITS = 3
) (
  input  logic                       CLK_10MHZ,
  input  logic                       RESET,
  anton_neopixel_pixel_buffer_if.slave apb,
  input  logic [PIXELS_BITS-1:0]     PIX_IDX,
  output logic [7:0]                 PIX_DATA,
  input  logic                       FRAME_DONE,
  output logic                       TX_EN
);
  localparam int DEPTH = 1 << PIXELS_BITS;
`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif
  localparam logic [7:0]           MAX_A = PIXELS_MAX[7:0];
  localparam logic [PIXELS_BITS:0] MAX_P = PIXELS_MAX[PIXELS_BITS:0];

  logic                   access, wr_acc, rd_acc;
  logic                   pix_ok, is_ctrl, is_stat, wr_err, rd_err;
  logic [PIXELS_BITS-1:0] apb_idx;
  logic                   run_q;
  logic                   rd_ready_q, rd_err_q;
  logic [7:0]             rd_data_q, rd_val;
  logic [PIXELS_BITS-1:0] pix_idx_q;
  logic [7:0]             pix_data_q;
  logic                   front, pending, wr_bank;
  logic [NBANKS-1:0][7:0] pix_rd_bank, apb_rd_bank;

  assign access  = apb.APB_PSELx & apb.APB_PENABLE;
  assign wr_acc  = access & apb.APB_PWRITE;
  // rd_ready_q gates the second read access cycle so the read fires exactly once
  assign rd_acc  = access & ~apb.APB_PWRITE & ~rd_ready_q;
  assign pix_ok  = ~apb.APB_PADDR[7] & ({1'b0, apb.APB_PADDR[6:0]} < MAX_A);
  assign is_ctrl = (apb.APB_PADDR == 8'h80);
  assign is_stat = (apb.APB_PADDR == 8'h81);
  assign wr_err  = ~(pix_ok | is_ctrl);
  assign rd_err  = ~(pix_ok | is_ctrl | is_stat);
  assign apb_idx = apb.APB_PADDR[PIXELS_BITS-1:0];
  assign wr_bank = ~front & (NBANKS > 1);

`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
  typedef enum logic {S_IDLE, S_PENDING} state_e;
  state_e state_q, state_d;
  logic   front_q, front_d, swap_req, swap_fire;

  assign swap_req = wr_acc & is_ctrl & apb.APB_PWDATA[1];

  always_ff @(posedge CLK_10MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
    end
  end

  // A FRAME_DONE coinciding with the request is ignored: IDLE only looks at swap_req
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (swap_req) state_d = S_PENDING;
      S_PENDING: if (FRAME_DONE || !run_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    swap_fire = (state_q == S_PENDING) & (FRAME_DONE | ~run_q);
    front_d   = front_q ^ swap_fire;
    pending   = (state_q == S_PENDING);
    front     = front_q;
  end
`else
  logic unused_frame_done;
  assign unused_frame_done = FRAME_DONE;
  assign front   = 1'b0;
  assign pending = 1'b0;
`endif

  for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
    logic [7:0] mem_q [DEPTH];
    always_ff @(posedge CLK_10MHZ) begin
      if (wr_acc && pix_ok && (wr_bank == 1'(gi)))
        mem_q[apb_idx] <= apb.APB_PWDATA;
    end
    assign pix_rd_bank[gi] = mem_q[pix_idx_q];
    assign apb_rd_bank[gi] = mem_q[apb_idx];
  end

  always_comb begin
    rd_val = 8'h00;
    if (pix_ok)       rd_val = apb_rd_bank[wr_bank];
    else if (is_ctrl) rd_val = {7'b0, run_q};
    else if (is_stat) rd_val = {6'b0, front, pending};
  end

  always_ff @(posedge CLK_10MHZ or posedge RESET) begin
    if (RESET) begin
      run_q      <= 1'b0;
      rd_ready_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= 8'h00;
      pix_idx_q  <= '0;
      pix_data_q <= 8'h00;
    end else begin
      if (wr_acc && is_ctrl) run_q <= apb.APB_PWDATA[0];
      rd_ready_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= rd_val;
        rd_err_q  <= rd_err;
      end
      pix_idx_q  <= PIX_IDX;
      pix_data_q <= ({1'b0, pix_idx_q} < MAX_P) ? pix_rd_bank[front] : 8'h00;
    end
  end

  // Write responses are combinational (zero wait state) and must vanish during reset
  assign apb.APB_PREADY  = rd_ready_q | (wr_acc & ~RESET);
  assign apb.APB_PRDATA  = rd_ready_q ? rd_data_q : 8'h00;
  assign apb.APB_PSLVERR = rd_ready_q ? rd_err_q : (wr_acc & ~RESET & wr_err);
  assign PIX_DATA        = pix_data_q;
  assign TX_EN           = run_q;
endmodule

// File: tb/tb_anton_neopixel_pixel_buffer.sv
// Directed bench for anton_neopixel_pixel_buffer with a reference model and scoreboard queue.
// Expectations follow ANTON_NEOPIXEL_DOUBLE_BUFFER_EN, same as the design build.
`timescale 1ns/1ps
module tb_anton_neopixel_pixel_buffer;
`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int PMAX = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pix_idx;
  logic [7:0] pix_data;
  logic       frame_done;
  logic       tx_en;

  anton_neopixel_pixel_buffer_if apb();

  anton_neopixel_pixel_buffer #(.PIXELS_MAX(PMAX), .PIXELS_BITS(3)) dut (
    .CLK_10MHZ (clk),
    .RESET     (rst),
    .apb       (apb),
    .PIX_IDX   (pix_idx),
    .PIX_DATA  (pix_data),
    .FRAME_DONE(frame_done),
    .TX_EN     (tx_en)
  );

  always #50 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] sb_q[$];
  logic [7:0] m_mem [2][8];
  logic       m_front, m_pending, m_run;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic back_bank();
    return DB ? ~m_front : 1'b0;
  endfunction

  function automatic logic [7:0] m_status();
    return DB ? {6'b0, m_front, m_pending} : 8'h00;
  endfunction

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, input logic fd);
    logic err, was_pending, bank;
    apb.APB_PSELx = 1'b1; apb.APB_PENABLE = 1'b0; apb.APB_PWRITE = 1'b1;
    apb.APB_PADDR = addr; apb.APB_PWDATA = data;
    @(negedge clk);
    apb.APB_PENABLE = 1'b1;
    frame_done = fd;
    #1;
    err = !((!addr[7] && addr[6:0] < PMAX) || addr == 8'h80);
    chk($sformatf("wr_ready_%02h", addr), 9'(apb.APB_PREADY), 9'd1);
    chk($sformatf("wr_err_%02h", addr), 9'(apb.APB_PSLVERR), 9'(err));
    bank = back_bank();
    was_pending = m_pending;
    if (DB && fd && was_pending) begin m_front = ~m_front; m_pending = 1'b0; end
    if (!err && !addr[7]) m_mem[bank][addr[2:0]] = data;
    if (addr == 8'h80) begin
      m_run = data[0];
      if (DB && data[1] && !was_pending) m_pending = 1'b1;
    end
    if (DB && m_pending && !m_run) begin m_front = ~m_front; m_pending = 1'b0; end
    @(negedge clk);
    apb.APB_PSELx = 1'b0; apb.APB_PENABLE = 1'b0; frame_done = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, input string tag);
    logic       err;
    logic [7:0] exp;
    int         n;
    err = !((!addr[7] && addr[6:0] < PMAX) || addr == 8'h80 || addr == 8'h81);
    if (!addr[7] && addr[6:0] < PMAX) exp = m_mem[back_bank()][addr[2:0]];
    else if (addr == 8'h80)           exp = {7'b0, m_run};
    else if (addr == 8'h81)           exp = m_status();
    else                              exp = 8'h00;
    sb_q.push_back({err, exp});
    apb.APB_PSELx = 1'b1; apb.APB_PENABLE = 1'b0; apb.APB_PWRITE = 1'b0; apb.APB_PADDR = addr;
    @(negedge clk);
    apb.APB_PENABLE = 1'b1;
    #1;
    chk({tag, "_wait"}, {apb.APB_PREADY, apb.APB_PRDATA}, 9'd0);
    n = 0;
    while (!apb.APB_PREADY && n < 4) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 9'(n), 9'd1);
    chk(tag, {apb.APB_PSLVERR, apb.APB_PRDATA}, sb_q.pop_front());
    apb.APB_PSELx = 1'b0; apb.APB_PENABLE = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_end"}, 9'(apb.APB_PREADY), 9'd0);
  endtask

  task automatic pix_check(input logic [2:0] idx, input string tag);
    pix_idx = idx;
    sb_q.push_back({1'b0, (idx < PMAX) ? m_mem[DB ? m_front : 1'b0][idx] : 8'h00});
    @(negedge clk); @(negedge clk); #1;
    chk(tag, 9'(pix_data), sb_q.pop_front());
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    if (DB && m_pending) begin m_front = ~m_front; m_pending = 1'b0; end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_done = 1'b0; pix_idx = 3'd0;
    apb.APB_PSELx = 1'b0; apb.APB_PENABLE = 1'b0; apb.APB_PWRITE = 1'b0;
    apb.APB_PADDR = 8'h00; apb.APB_PWDATA = 8'h00;
    m_front = 1'b0; m_pending = 1'b0; m_run = 1'b0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < 8; i++) m_mem[b][i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_apb", {apb.APB_PREADY, apb.APB_PSLVERR, apb.APB_PRDATA[6:0]}, 9'd0);
    chk("rst_prdata", 9'(apb.APB_PRDATA), 9'd0);
    chk("rst_pix_tx", {tx_en, pix_data}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    apb_read(8'h81, "rst_status");

    // Clear both banks so later pixel expectations are defined
    for (int i = 0; i < PMAX; i++) apb_write(8'(i), 8'h00, 1'b0);
    apb_write(8'h80, 8'h02, 1'b0);
    for (int i = 0; i < PMAX; i++) apb_write(8'(i), 8'h00, 1'b0);
    apb_write(8'h80, 8'h02, 1'b0);

    // Frame-aligned swap with RUN=1
    apb_write(8'h02, 8'hA5, 1'b0);
    apb_write(8'h80, 8'h03, 1'b0);
    chk("tx_en_run", 9'(tx_en), 9'd1);
    pix_check(3'd2, "pix2_before_fd");
    apb_read(8'h81, "status_pending");
    pix_check(3'd2, "pix2_still_old");
    pulse_fd();
    pix_check(3'd2, "pix2_after_fd");
    apb_read(8'h81, "status_after_fd");

    // Immediate swap with RUN=0
    apb_write(8'h80, 8'h00, 1'b0);
    apb_write(8'h00, 8'h3C, 1'b0);
    apb_write(8'h80, 8'h02, 1'b0);
    apb_read(8'h81, "status_immediate");
    pix_check(3'd0, "pix0_immediate");
    chk("tx_en_stop", 9'(tx_en), 9'd0);

    // Range and address decode
    apb_write(8'h05, 8'h11, 1'b0);
    apb_read(8'h05, "rd_px5_oor");
    apb_write(8'h04, 8'h77, 1'b0);
    apb_read(8'h04, "rd_px4");
    apb_read(8'h7F, "rd_px127_oor");
    apb_read(8'h82, "rd_unmapped");
    apb_write(8'h81, 8'hFF, 1'b0);
    apb_write(8'hC0, 8'h12, 1'b0);
    apb_read(8'h80, "rd_ctrl");
    pix_check(3'd5, "pix5_oor");
    pix_check(3'd7, "pix7_oor");

    // SWAP coinciding with FRAME_DONE, then a second SWAP while pending
    apb_write(8'h80, 8'h01, 1'b0);
    apb_write(8'h80, 8'h03, 1'b1);
    apb_read(8'h81, "status_same_cycle");
    apb_write(8'h80, 8'h03, 1'b0);
    apb_read(8'h81, "status_second_swap");
    pulse_fd();
    apb_read(8'h81, "status_one_toggle");
    pulse_fd();
    apb_read(8'h81, "status_no_double");

    // Back-bank readback and pixel fetch
    apb_write(8'h01, 8'h5A, 1'b0);
    apb_read(8'h01, "rd_px1");
    pix_check(3'd1, "pix1_front");
    pix_check(3'd4, "pix4_front");

    // Reset while a swap is pending and a read is in its data cycle
    apb_write(8'h03, 8'hC3, 1'b0);
    apb_write(8'h80, 8'h03, 1'b0);
    pix_idx = 3'd3;
    apb.APB_PSELx = 1'b1; apb.APB_PENABLE = 1'b0; apb.APB_PWRITE = 1'b0; apb.APB_PADDR = 8'h01;
    @(negedge clk);
    apb.APB_PENABLE = 1'b1;
    @(negedge clk); #1;
    chk("mid_read_ready", 9'(apb.APB_PREADY), 9'd1);
    #10 rst = 1'b1;
    #1;
    chk("arst_apb", {apb.APB_PREADY, apb.APB_PRDATA}, 9'd0);
    chk("arst_err", 9'(apb.APB_PSLVERR), 9'd0);
    chk("arst_pix_tx", {tx_en, pix_data}, 9'd0);
    apb.APB_PSELx = 1'b0; apb.APB_PENABLE = 1'b0;
    m_front = 1'b0; m_pending = 1'b0; m_run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_fd();
    apb_read(8'h81, "status_after_rst");
    pix_check(3'd3, "pix3_after_rst");
    chk("tx_en_after_rst", 9'(tx_en), 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
